bios_fetch_unit: RTL and testbench
==================================

// Module: bios_fetch_unit
// PURPOSE
//  Instruction fetch front-end that drives port A of the 4096x32 synchronous-read bios_mem ROM.
//  - Generates the PC and the word address.
//  - Absorbs the ROM's 1-cycle read latency.
//  - Presents {inst, pc} to decode over a valid/ready handshake; handles redirects and halt.
//  - Stalls by de-asserting bios_ena, so douta holds its value (no skid RAM needed).
// PARAMETERS
//  RESET_PC  32'h4000_0000  PC fetched first after reset.
//  ADDR_W    12             ROM word-address width; bios_addra = pc[ADDR_W+1:2].
//  DATA_W    32             Instruction width.
// PORTS
//  clk             in   1       Single clock; all state on posedge.
//  rst             in   1       Synchronous, active-high reset.
//  bios_ena        out  1       ROM port-A enable; 0 holds douta.
//  bios_addra      out  ADDR_W  ROM word address.
//  bios_douta      in   DATA_W  ROM data; valid the cycle after an enabled request.
//  redirect_valid  in   1       Branch/jump redirect from downstream.
//  redirect_pc     in   32      Redirect target; bits [1:0] are ignored (forced 0).
//  halt            in   1       Level-sensitive. Stops new fetches.
//  out_valid       out  1       out_inst/out_pc are valid.
//  out_ready       in   1       Decode accepts this cycle.
//  out_inst        out  DATA_W  Fetched instruction (= bios_douta).
//  out_pc          out  32      PC of out_inst.
// BEHAVIOUR
//  - Registers:
//    - state {BOOT, RUN, STALL, HALT}
//    - issue_pc[31:0]: next PC to request
//    - resp_valid, resp_pc[31:0]: the request in flight / presented
//  - Reset: state=BOOT, issue_pc=RESET_PC, resp_valid=0, resp_pc=0. Outputs in reset: out_valid=0, bios_ena=0.
//  - Combinational outputs:
//    - out_valid = resp_valid & ~redirect_valid.
//    - out_inst = bios_douta; out_pc = resp_pc.
//    - fire = out_valid & out_ready.
//  - Address mux: bios_addra = redirect_valid ? redirect_pc[13:2] : issue_pc[13:2].
//  - BOOT: bios_ena=0 for one cycle, then -> RUN.
//  - RUN / STALL:
//    - adv = ~halt & (~resp_valid | fire).
//    - bios_ena = adv | redirect_valid.
//    - On bios_ena: resp_valid<=1, resp_pc<=requested PC, issue_pc<=requested PC+4.
//    - On fire & halt (no redirect): resp_valid<=0.
//  - Transitions:
//    - RUN -> STALL when out_valid & ~out_ready.
//    - STALL -> RUN on fire or redirect.
//    - RUN/STALL -> HALT when halt & ~resp_valid, or halt & fire.
//  - HALT: bios_ena=0, out_valid=0. Leaves only on redirect_valid, which issues redirect_pc and -> RUN.
//  - Throughput: 1 instr/cycle with out_ready=1. Latency reset->first out_valid = 3 cycles (BOOT, issue, data).
//  - Redirect:
//    - Kills the presented instruction in the same cycle (out_valid=0; no fire).
//    - Target is presented next cycle. Redirect wins over halt, stall and fire.
//  - Stall: bios_ena=0 guarantees bios_douta, out_pc and bios_addra are stable until fire.
//  - Wrap: issue_pc is a 32-bit add (wraps 0xFFFF_FFFC -> 0). The ROM address wraps modulo 4096 words
//    (0x4000_3FFC -> 0x4000_4000 reads word 0). No fault is raised.
//  - Reset mid-operation: the in-flight response is discarded; restart from BOOT.
// CONFIGURATION
//  - FETCH_PERF_EN defined: adds output ports fetch_cnt[31:0] and stall_cnt[31:0].
//    - fetch_cnt: +1 per fire.
//    - stall_cnt: +1 per cycle with out_valid & ~out_ready.
//    - Both reset to 0 and wrap silently.
//  - FETCH_PERF_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Package fetch_pkg holds:
//    - fetch_state_t enum (BOOT, RUN, STALL, HALT)
//    - FETCH_RESET_PC default, PC_W=32, INST_W=32
//  - Sub-module fetch_pc_gen: issue_pc register, +4 adder, redirect mux, bios_addra slice.
//    The top holds the FSM, response tracking and the optional counters.
// TESTING
//  - Reset boot: rst 2 cycles, out_ready=1 -> bios_ena=0 in BOOT; out_pc 4000_0000, 4000_0004, 4000_0008 on
//    consecutive cycles; out_inst matches .coe words 0,1,2.
//  - Backpressure: out_ready=0 for 5 cycles at pc 4000_0010 -> bios_ena=0; out_inst/out_pc stable; then out_ready=1
//    -> 4000_0014 next cycle with no gap. With FETCH_PERF_EN: stall_cnt=5.
//  - Redirect: redirect_pc=4000_0100 while 4000_0008 is presented -> out_valid=0 that cycle; next cycle
//    out_pc=4000_0100 with word 0x40. Redirect during a stall behaves the same.
//  - Halt: halt=1 with out_ready=0 -> current instr held until accepted, then out_valid=0, bios_ena=0.
//    Then redirect to 4000_0020 -> fetch resumes at word 8.
//  - Wrap: redirect to 4000_3FFC -> next out_pc=4000_4000 with out_inst = word 0.
//  - Mid-run reset: rst pulsed during a stall -> out_valid=0 next cycle; restart at RESET_PC; counters=0.

Source files
------------

// File: rtl/bios_fetch_unit_pkg.sv
// Shared fetch types and defaults: FSM state encoding, reset PC, bus widths.
// Pure declarations; no logic or timing.
package fetch_pkg;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, HALT = 2'd3} fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h4000_0000;
    localparam int          PC_W           = 32;
    localparam int          INST_W         = 32;
    localparam int          ROM_ADDR_W     = 12;
endpackage

// File: rtl/bios_fetch_unit_if.sv
// ROM port-A and decode-side signals of the fetch unit; master = fetch unit, slave = ROM/decode side.
// Combinational bundle only; no latency and no state of its own.
interface bios_fetch_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    import fetch_pkg::*;

    logic              bios_ena;
    logic [ADDR_W-1:0] bios_addra;
    logic [DATA_W-1:0] bios_douta;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output bios_ena, bios_addra, out_valid, out_inst, out_pc,
        input  bios_douta, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  bios_ena, bios_addra, out_valid, out_inst, out_pc,
        output bios_douta, redirect_valid, redirect_pc, halt, out_ready
    );
endinterface

// File: rtl/bios_fetch_unit_pc_gen.sv
// Next-PC generator: issue_pc register, +4 increment, redirect mux and ROM word-address slice.
// Requested PC/address are combinational; issue_pc only advances when the request is loaded.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int              ADDR_W   = ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_redirect_valid,
    input  logic [PC_W-1:0]   i_redirect_pc,
    output logic [PC_W-1:0]   o_req_pc,
    output logic [ADDR_W-1:0] o_addra
);
    logic [PC_W-1:0] r_issue_pc;
    logic [PC_W-1:0] w_req_pc;

    // Redirect targets are word aligned; the low two bits are dropped here.
    assign w_req_pc = i_redirect_valid ? (i_redirect_pc & ~PC_W'(3)) : r_issue_pc;
    assign o_req_pc = w_req_pc;
    assign o_addra  = w_req_pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_pc <= RESET_PC;
        end else if (i_load) begin
            r_issue_pc <= w_req_pc + PC_W'(4);
        end
    end
endmodule

// File: rtl/bios_fetch_unit.sv
// Fetch front-end for the bios ROM: 3 cycles reset->first instruction, then 1 instr/cycle.
// Backpressure drops bios_ena so ROM data holds; optional counters under FETCH_PERF_EN.
module bios_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int              ADDR_W   = ROM_ADDR_W,
    parameter int              DATA_W   = INST_W
) (
    input  logic              clk,
    input  logic              rst,
    bios_fetch_if.master      fif
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    localparam logic [1:0] S_BOOT  = BOOT;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_STALL = STALL;
    localparam logic [1:0] S_HALT  = HALT;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_resp_valid;
    logic [PC_W-1:0] r_resp_pc;
    logic [PC_W-1:0] w_req_pc;
    logic            w_active;
    logic            w_out_valid;
    logic            w_fire;
    logic            w_adv;
    logic            w_ena;

    assign w_active    = (r_state == S_RUN) || (r_state == S_STALL);
    assign w_out_valid = w_active & r_resp_valid & ~fif.redirect_valid;
    assign w_fire      = w_out_valid & fif.out_ready;
    assign w_adv       = ~fif.halt & (~r_resp_valid | w_fire);

    assign fif.out_valid = w_out_valid;
    assign fif.out_inst  = fif.bios_douta;
    assign fif.out_pc    = r_resp_pc;
    assign fif.bios_ena  = w_ena;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_gen (
        .clk              (clk),
        .rst              (rst),
        .i_load           (w_ena),
        .i_redirect_valid (fif.redirect_valid),
        .i_redirect_pc    (fif.redirect_pc),
        .o_req_pc         (w_req_pc),
        .o_addra          (fif.bios_addra)
    );

    always_comb begin
        w_ena       = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN, S_STALL: begin
                w_ena = w_adv | fif.redirect_valid;
                if (fif.redirect_valid)
                    w_state_nxt = S_RUN;
                else if (fif.halt && (!r_resp_valid || w_fire))
                    w_state_nxt = S_HALT;
                else if (w_out_valid && !fif.out_ready)
                    w_state_nxt = S_STALL;
                else
                    w_state_nxt = S_RUN;
            end
            S_HALT: begin
                w_ena = fif.redirect_valid;
                if (fif.redirect_valid)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_resp_valid <= 1'b0;
            r_resp_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ena) begin
                r_resp_valid <= 1'b1;
                r_resp_pc    <= w_req_pc;
            end else if (w_fire && fif.halt) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_fire)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (w_out_valid && !fif.out_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bios_fetch_unit.sv
// Directed + randomized bench for bios_fetch_unit against a transaction-level model of the fetch stream.
module tb_bios_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bios_fetch_if fif ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    bios_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    logic [31:0] rom [4096];
    always @(posedge clk) if (fif.bios_ena) fif.bios_douta <= rom[fif.bios_addra];

    int n_pass = 0;
    int n_total = 0;

    // Model: what the consumer should see, in terms of presented instructions.
    logic        m_boot, m_has, m_halted, prev_rs;
    logic [31:0] m_pc, m_next, m_fires, m_stalls;
    logic        obs_v, obs_ena;
    logic [31:0] obs_pc, obs_inst, obs_fcnt, obs_scnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic [31:0] rpc, input logic h,
                        input logic rdy, input logic rs);
        logic        e_v, e_ena, e_fire;
        logic [31:0] req;
        @(negedge clk);
        rst = rs;
        fif.redirect_valid = r;
        fif.redirect_pc = rpc;
        fif.halt = h;
        fif.out_ready = rdy;
        #1;
        obs_v = fif.out_valid; obs_ena = fif.bios_ena;
        obs_pc = fif.out_pc;   obs_inst = fif.out_inst;
`ifdef FETCH_PERF_EN
        obs_fcnt = fetch_cnt;  obs_scnt = stall_cnt;
`else
        obs_fcnt = 32'd0;      obs_scnt = 32'd0;
`endif
        if (rs) begin
            if (prev_rs) begin
                check("rst_ena", {31'd0, obs_ena}, 32'd0);
                check("rst_valid", {31'd0, obs_v}, 32'd0);
            end
            m_boot = 1'b1; m_has = 1'b0; m_halted = 1'b0; m_next = RST_PC;
            m_fires = 0; m_stalls = 0;
        end else if (m_boot) begin
            check("boot_ena", {31'd0, obs_ena}, 32'd0);
            check("boot_valid", {31'd0, obs_v}, 32'd0);
            m_boot = 1'b0;
        end else begin
            e_v    = m_has & ~r;
            e_fire = e_v & rdy;
            e_ena  = r | (~m_halted & ~h & (~m_has | e_fire));
            req    = r ? {rpc[31:2], 2'b00} : m_next;
            check("ena", {31'd0, obs_ena}, {31'd0, e_ena});
            check("out_valid", {31'd0, obs_v}, {31'd0, e_v});
            if (e_v) begin
                check("out_pc", obs_pc, m_pc);
                check("out_inst", obs_inst, rom[m_pc[13:2]]);
            end
            if (e_ena) check("addra", {20'd0, fif.bios_addra}, {20'd0, req[13:2]});
`ifdef FETCH_PERF_EN
            check("fetch_cnt", obs_fcnt, m_fires);
            check("stall_cnt", obs_scnt, m_stalls);
`endif
            if (e_fire) m_fires++;
            if (e_v && !rdy) m_stalls++;
            if (e_ena) begin
                m_has = 1'b1; m_pc = req; m_next = req + 32'd4; m_halted = 1'b0;
            end else if (h && (e_fire || !m_has)) begin
                m_has = 1'b0; m_halted = 1'b1;
            end
        end
        prev_rs = rs;
    endtask

    initial begin
        logic        rh;
        logic [31:0] rpc;
        prev_rs = 1'b0;
        fif.redirect_valid = 1'b0; fif.redirect_pc = '0; fif.halt = 1'b0; fif.out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) rom[i] = $urandom;

        // Reset and boot
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0);
            check("seq_pc", obs_pc, RST_PC + 32'(4 * i));
            check("seq_inst", obs_inst, rom[i]);
        end

        // Backpressure at 0x4000_0010
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            check("stall_pc", obs_pc, 32'h4000_0010);
        end
        step(0, 0, 0, 1, 0);
        check("stall_fire_pc", obs_pc, 32'h4000_0010);
`ifdef FETCH_PERF_EN
        check("stall_cnt5", obs_scnt, 32'd5);
`endif
        step(0, 0, 0, 1, 0);
        check("after_stall_pc", obs_pc, 32'h4000_0014);

        // Redirect while presenting, then during a stall (low bits ignored)
        step(1, 32'h4000_0100, 0, 1, 0);
        check("redir_kill", {31'd0, obs_v}, 32'd0);
        step(0, 0, 0, 1, 0);
        check("redir_pc", obs_pc, 32'h4000_0100);
        check("redir_inst", obs_inst, rom[64]);
        step(0, 0, 0, 0, 0);
        step(1, 32'h4000_0203, 0, 0, 0);
        check("redir_stall_kill", {31'd0, obs_v}, 32'd0);
        step(0, 0, 0, 1, 0);
        check("redir_stall_pc", obs_pc, 32'h4000_0200);

        // Halt with backpressure, then resume by redirect
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("halt_hold", {31'd0, obs_v}, 32'd1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check("halted_valid", {31'd0, obs_v}, 32'd0);
        check("halted_ena", {31'd0, obs_ena}, 32'd0);
        step(0, 0, 0, 1, 0);
        check("halt_sticky", {31'd0, obs_ena}, 32'd0);
        step(1, 32'h4000_0020, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("resume_pc", obs_pc, 32'h4000_0020);
        check("resume_inst", obs_inst, rom[8]);

        // ROM-address wrap and 32-bit PC wrap
        step(1, 32'h4000_3FFC, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("wrap_pc", obs_pc, 32'h4000_4000);
        check("wrap_inst", obs_inst, rom[0]);
        step(1, 32'hFFFF_FFFC, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("pc32_wrap", obs_pc, 32'h0000_0000);

        // Reset during a stall
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        check("midrst_valid", {31'd0, obs_v}, 32'd0);
`ifdef FETCH_PERF_EN
        check("midrst_fcnt", obs_fcnt, 32'd0);
        check("midrst_scnt", obs_scnt, 32'd0);
`endif
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("midrst_pc", obs_pc, RST_PC);

        // Randomized traffic
        rh = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 4) rh = ~rh;
            rpc = ($urandom_range(0, 3) == 0) ? (32'h4000_3FF0 + 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(($urandom_range(0, 99) < 7), rpc, rh, ($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
